mtr_drv_pwm: RTL and testbench
==============================

# mtr_drv_pwm

Converts the signed 12-bit wheel speed commands `lft_spd`/`rght_spd` from the Segway math block into sign-magnitude H-bridge drive signals (one forward PWM and one reverse PWM per wheel). Both wheels share one free-running 2048-clock PWM period. Commands are sampled only at period boundaries. A full dead period (both bridge legs low) is inserted on every direction reversal, so a wheel is never driven straight from forward into reverse.

## Interface
- `PWM_W`, default 11: PWM counter/duty width; the period is 2^PWM_W clocks.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. Asynchronous and active-low.
- `lft_spd`, input, 12: signed left speed command.
- `rght_spd`, input, 12: signed right speed command.
- `pwr_up`, input, 1: drive enable. Low forces coast.
- `lft_fwd_pwm`, output, 1: left bridge forward drive (registered).
- `lft_rev_pwm`, output, 1: left bridge reverse drive (registered).
- `rght_fwd_pwm`, output, 1: right bridge forward drive (registered).
- `rght_rev_pwm`, output, 1: right bridge reverse drive (registered).
- `PWM_synch`, output, 1: high for the single cycle in which `cnt == 2^PWM_W-1`.

## Operation
- `cnt`: free-running `PWM_W`-bit up-counter. It wraps 7FF→000, is never stalled, and ignores `pwr_up`.
- **Sampling:** on the edge leaving `cnt == 7FF` (that is, while `PWM_synch` is high), each side latches its `duty` and next state from its speed input.
- **Magnitude:** `duty = |spd|` as 11 bits. `-2048` saturates to `7FF`; positive values pass through unchanged.
- **Per-side FSM states:** COAST, FWD, REV, DEAD. The reset state is COAST.
- **Transitions at each sample:**
  - `spd == 0`: go to COAST from any state.
  - `spd > 0`:
    - from REV, go to DEAD;
    - from COAST, FWD or DEAD, go to FWD.
  - `spd < 0`:
    - from FWD, go to DEAD;
    - from COAST, REV or DEAD, go to REV.
- **DEAD:**
  - Lasts exactly one period with both outputs low.
  - The following sample never re-enters DEAD.
  - The new command is always sampled, so a command change during DEAD takes effect directly.
- **Output rule:** forward output = `state == FWD && cnt < duty`; reverse output = `state == REV && cnt < duty`. Each is registered, so the output level reflects the compare on the previous cycle.
- **Exclusivity:** forward and reverse outputs of one side are never high in the same cycle. This is the primary assertion.
- **`pwr_up` low:**
  - Synchronously forces both sides to COAST with `duty = 0`, so all four outputs are low on the next edge.
  - It overrides sampling.
  - When `pwr_up` rises, drive resumes at the next sample, starting from COAST, so no dead period is inserted.
- **Mid-period command changes:** ignored until the next sample, which guarantees glitch-free duty.

## Timing
- **Reset values:**
  - `cnt = 0`, all `duty = 0`, both FSMs in COAST, all four PWM outputs 0.
  - `PWM_synch = 0` (it is decoded from `cnt`).
- **Command latency:** the sample edge is at `cnt` 7FF→000. Outputs first reflect the new duty in the cycle where `cnt == 1`.
- **High time per period:** an output is high for the cycles with `cnt ∈ [1, duty]`, which is exactly `duty` cycles.
  - At `cnt == 0` every output is low, because the compare was against `cnt == 7FF` and `duty ≤ 7FF`.
  - `duty = 0` gives 0 high cycles; `duty = 7FF` gives 2047 high cycles and 1 low cycle.
- **Reversal delay:** the sample that detects a sign flip starts one full DEAD period (2048 cycles). Drive in the new direction begins one cycle after the following wrap.
- **Simultaneous events:** `pwr_up` low on the sample edge takes priority, giving COAST.
- **Reset mid-period:** outputs drop immediately (asynchronous) and the counter restarts at 0.

## Structure
- **Shared package `mtr_drv_pkg`:**
  - `typedef enum logic [1:0] {COAST, FWD, REV, DEAD} drv_state_t`
  - `PWM_W`
  - `PWM_MAX = 2^PWM_W-1`
- **Top level:** holds the single shared counter and `PWM_synch` decode.
- **Sub-module `mtr_side_drv`:** instantiated twice (left and right). It contains:
  - the magnitude/saturation logic;
  - the duty register;
  - the FSM;
  - the two output flops.

## Test plan
- **Forward drive:** reset, `pwr_up=1`, `lft_spd=+0x100`.
  - `lft_fwd_pwm` is high exactly 256 cycles per period, at `cnt` 1..256.
  - `lft_rev_pwm` stays 0.
  - Right outputs stay 0 with `rght_spd=0`.
- **Saturation:** `rght_spd=-0x800`.
  - `rght_rev_pwm` is high 2047 cycles per period and low only at `cnt == 0`.
  - `rght_fwd_pwm` stays 0.
- **Reversal:** `lft_spd` changes from +0x200 to -0x200 at `cnt == 0x300`.
  - The current period completes the forward pulse unchanged.
  - The next full period has both left outputs low.
  - The period after that has `lft_rev_pwm` high for 512 cycles.
- **Coast then drive:** `lft_spd` goes +0x80, then 0, then -0x80.
  - The 0 period has both outputs low.
  - Reverse drive starts at the very next period with no DEAD.
- **`pwr_up` toggle:** deassert `pwr_up` at `cnt == 0x010` while `duty = 0x400`.
  - All outputs are low on the next edge.
  - After reassertion, drive at 0x400 resumes at the next sample with no DEAD.
- **Async reset mid-pulse:** assert `rst_n=0` asynchronously mid-pulse.
  - All outputs drop without a clock edge, and `cnt` reads 0.
  - Throughout every test, a checker asserts fwd/rev exclusivity on both sides.

Source files
------------

// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the sign-magnitude H-bridge PWM driver.
package mtr_drv_pkg;

  localparam int unsigned PWM_W   = 11;
  localparam int unsigned SPD_W   = 12;
  localparam int unsigned PWM_MAX = (1 << PWM_W) - 1;

  typedef enum logic [1:0] {
    COAST = 2'd0,
    FWD   = 2'd1,
    REV   = 2'd2,
    DEAD  = 2'd3
  } drv_state_t;

endpackage

// File: rtl/mtr_side_drv.sv
// One wheel: samples a signed speed at the period boundary, holds duty and
// drive state, and produces the registered forward/reverse PWM pair.
module mtr_side_drv #(
  parameter int unsigned PWM_W = mtr_drv_pkg::PWM_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [mtr_drv_pkg::SPD_W-1:0]  spd_i,
  input  logic                           pwr_up_i,
  input  logic                           synch_i,
  input  logic [PWM_W-1:0]               cnt_i,
  output logic                           fwd_o,
  output logic                           rev_o
);
  import mtr_drv_pkg::*;

  drv_state_t          state_q, state_d;
  logic [PWM_W-1:0]    duty_q, duty_d;
  logic                fwd_q, fwd_d;
  logic                rev_q, rev_d;
  logic [SPD_W-1:0]    neg_spd_c;
  logic [SPD_W-2:0]    mag_c;
  logic                spd_zero_c;
  logic                spd_neg_c;

  // Magnitude; only -2048 sets the top bit of the negation and saturates.
  always_comb begin
    neg_spd_c  = SPD_W'(-spd_i);
    spd_zero_c = (spd_i == '0);
    spd_neg_c  = spd_i[SPD_W-1];
    mag_c      = spd_i[SPD_W-2:0];
    if (spd_neg_c) begin
      if (neg_spd_c[SPD_W-1]) mag_c = '1;
      else                    mag_c = neg_spd_c[SPD_W-2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COAST;
      duty_q  <= '0;
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      fwd_q   <= fwd_d;
      rev_q   <= rev_d;
    end
  end

  // Next state / duty; DEAD is only ever entered from an opposite drive state.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    fwd_d   = 1'b0;
    rev_d   = 1'b0;

    if (!pwr_up_i) begin
      state_d = COAST;
      duty_d  = '0;
    end else if (synch_i) begin
      duty_d = PWM_W'(mag_c);
      if (spd_zero_c) begin
        state_d = COAST;
      end else if (!spd_neg_c) begin
        state_d = (state_q == REV) ? DEAD : FWD;
      end else begin
        state_d = (state_q == FWD) ? DEAD : REV;
      end
    end

    // Gated by pwr_up so a drop clears the outputs on the very next edge.
    fwd_d = pwr_up_i && (state_q == FWD) && (cnt_i < duty_q);
    rev_d = pwr_up_i && (state_q == REV) && (cnt_i < duty_q);
  end

  assign fwd_o = fwd_q;
  assign rev_o = rev_q;

  excl_a: assert property (@(posedge clk) disable iff (!rst_n) !(fwd_q && rev_q));

endmodule

// File: rtl/mtr_drv_pwm.sv
// Two-wheel H-bridge PWM driver: shared free-running period counter plus one
// sign-magnitude drive channel per wheel.
module mtr_drv_pwm #(
  parameter int unsigned PWM_W = mtr_drv_pkg::PWM_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [mtr_drv_pkg::SPD_W-1:0]  lft_spd,
  input  logic [mtr_drv_pkg::SPD_W-1:0]  rght_spd,
  input  logic                           pwr_up,
  output logic                           lft_fwd_pwm,
  output logic                           lft_rev_pwm,
  output logic                           rght_fwd_pwm,
  output logic                           rght_rev_pwm,
  output logic                           PWM_synch
);
  import mtr_drv_pkg::*;

  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic [PWM_W-1:0] cnt_q;
  logic             synch_q;

  // Synch is registered off cnt-1 so it is high exactly while cnt == max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      synch_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + PWM_W'(1);
      synch_q <= (cnt_q == (CNT_MAX - PWM_W'(1)));
    end
  end

  assign PWM_synch = synch_q;

  mtr_side_drv #(.PWM_W(PWM_W)) u_lft (
    .clk      (clk),
    .rst_n    (rst_n),
    .spd_i    (lft_spd),
    .pwr_up_i (pwr_up),
    .synch_i  (synch_q),
    .cnt_i    (cnt_q),
    .fwd_o    (lft_fwd_pwm),
    .rev_o    (lft_rev_pwm)
  );

  mtr_side_drv #(.PWM_W(PWM_W)) u_rght (
    .clk      (clk),
    .rst_n    (rst_n),
    .spd_i    (rght_spd),
    .pwr_up_i (pwr_up),
    .synch_i  (synch_q),
    .cnt_i    (cnt_q),
    .fwd_o    (rght_fwd_pwm),
    .rev_o    (rght_rev_pwm)
  );

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Directed bench for mtr_drv_pwm: per-period high-time and window checks.
module tb_mtr_drv_pwm;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [11:0] lft_spd = '0;
  logic signed [11:0] rght_spd = '0;
  logic               pwr_up = 1'b0;
  logic               lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm;
  logic               PWM_synch;

  mtr_drv_pwm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .pwr_up       (pwr_up),
    .lft_fwd_pwm  (lft_fwd_pwm),
    .lft_rev_pwm  (lft_rev_pwm),
    .rght_fwd_pwm (rght_fwd_pwm),
    .rght_rev_pwm (rght_rev_pwm),
    .PWM_synch    (PWM_synch)
  );

  always #5 clk = ~clk;

  logic [10:0] cnt_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_m <= '0;
    else        cnt_m <= cnt_m + 11'd1;
  end

  wire [3:0] outs = {rght_rev_pwm, rght_fwd_pwm, lft_rev_pwm, lft_fwd_pwm};

  int checks = 0;
  int failures = 0;
  int sync_err = 0;
  int excl_err = 0;
  int hi_cnt[4];
  int first_hi[4];
  int last_hi[4];

  always @(negedge clk) begin
    if (rst_n) begin
      if (PWM_synch !== (cnt_m == 11'h7FF)) sync_err++;
      if ((lft_fwd_pwm && lft_rev_pwm) || (rght_fwd_pwm && rght_rev_pwm)) excl_err++;
    end
  end

  typedef struct {
    logic               p;
    logic signed [11:0] l;
    logic signed [11:0] r;
    int                 e[4];
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int idx, input int exp);
    logic ok;
    ok = (hi_cnt[idx] == exp) &&
         ((exp == 0) || (first_hi[idx] == 1 && last_hi[idx] == exp));
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: high=%0d first_cnt=%0d last_cnt=%0d, expected high=%0d at cnt 1..%0d",
               name, hi_cnt[idx], first_hi[idx], last_hi[idx], exp, exp);
    end
  endtask

  task automatic check_period(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
    check_out({tag, "_lf"}, 0, e0);
    check_out({tag, "_lr"}, 1, e1);
    check_out({tag, "_rf"}, 2, e2);
    check_out({tag, "_rr"}, 3, e3);
  endtask

  // Runs one full period starting from the negedge at cnt 7FF; optional
  // input change applied at the negedge where cnt == chg_at.
  task automatic run_period(input int chg_at, input logic p,
                            input logic signed [11:0] l, input logic signed [11:0] r);
    for (int i = 0; i < 4; i++) begin
      hi_cnt[i] = 0; first_hi[i] = -1; last_hi[i] = -1;
    end
    for (int k = 0; k < 2048; k++) begin
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (outs[i]) begin
          hi_cnt[i]++;
          if (first_hi[i] < 0) first_hi[i] = int'(cnt_m);
          last_hi[i] = int'(cnt_m);
        end
      end
      if (int'(cnt_m) == chg_at) begin
        pwr_up = p; lft_spd = l; rght_spd = r;
      end
    end
  endtask

  task automatic align_to_wrap(input string name);
    int found;
    found = 0;
    for (int k = 0; k < 4100 && found == 0; k++) begin
      if (cnt_m == 11'h7FF) found = 1;
      else begin
        @(posedge clk); @(negedge clk);
      end
    end
    chk(name, found, 1);
  endtask

  initial begin
    tbl[0]  = '{1'b1,  12'sd256,   12'sd0,    '{256, 0, 0, 0}};
    tbl[1]  = '{1'b1,  12'sd256,   12'sh800,  '{256, 0, 0, 2047}};
    tbl[2]  = '{1'b1,  12'sd512,   12'sh800,  '{512, 0, 0, 2047}};
    tbl[3]  = '{1'b1, -12'sd512,   12'sd2047, '{0, 0, 0, 0}};
    tbl[4]  = '{1'b1, -12'sd512,   12'sd2047, '{0, 512, 2047, 0}};
    tbl[5]  = '{1'b1,  12'sd128,   12'sd0,    '{0, 0, 0, 0}};
    tbl[6]  = '{1'b1,  12'sd0,     12'sd0,    '{0, 0, 0, 0}};
    tbl[7]  = '{1'b1, -12'sd128,   12'sd0,    '{0, 128, 0, 0}};
    tbl[8]  = '{1'b1,  12'sd128,  -12'sd1,    '{0, 0, 0, 1}};
    tbl[9]  = '{1'b1, -12'sd128,  -12'sd1,    '{0, 128, 0, 1}};
    tbl[10] = '{1'b1,  12'sd2047,  12'sd1,    '{0, 0, 0, 0}};
    tbl[11] = '{1'b1, -12'sd2047,  12'sd1,    '{0, 2047, 1, 0}};
    tbl[12] = '{1'b0,  12'sd1024,  12'sd1024, '{0, 0, 0, 0}};
    tbl[13] = '{1'b1, -12'sd1024,  12'sd1024, '{0, 1024, 1024, 0}};

    #1 rst_n = 1'b0;
    #1;
    chk("reset_outs", int'(outs), 0);
    chk("reset_synch", int'(PWM_synch), 0);
    chk("reset_cnt", int'(dut.cnt_q), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    align_to_wrap("align_initial");

    foreach (tbl[i]) begin
      pwr_up = tbl[i].p; lft_spd = tbl[i].l; rght_spd = tbl[i].r;
      run_period(-1, 1'b0, '0, '0);
      check_period($sformatf("row%0d", i), tbl[i].e[0], tbl[i].e[1], tbl[i].e[2], tbl[i].e[3]);
    end

    // pwr_up dropped at cnt 0x010 while in REV/FWD at duty 0x400
    run_period(16, 1'b0, -12'sd1024, 12'sd1024);
    check_period("pwr_drop", 0, 16, 16, 0);
    run_period(256, 1'b1, 12'sd1024, -12'sd1024);
    check_period("pwr_off", 0, 0, 0, 0);
    run_period(-1, 1'b0, '0, '0);
    check_period("pwr_resume", 1024, 0, 0, 1024);

    // Reversal requested mid-period at cnt 0x300
    lft_spd = 12'sd512; rght_spd = 12'sd0;
    run_period(768, 1'b1, -12'sd512, 12'sd0);
    check_period("rev_cur", 512, 0, 0, 0);
    run_period(-1, 1'b0, '0, '0);
    check_period("rev_dead", 0, 0, 0, 0);
    run_period(-1, 1'b0, '0, '0);
    check_period("rev_new", 0, 512, 0, 0);

    // Coast between directions inserts no dead period
    lft_spd = 12'sd128;
    run_period(-1, 1'b0, '0, '0);
    check_period("cd_dead", 0, 0, 0, 0);
    run_period(64, 1'b1, 12'sd0, 12'sd0);
    check_period("cd_fwd", 128, 0, 0, 0);
    run_period(2047, 1'b1, -12'sd128, 12'sd0);
    check_period("cd_coast", 0, 0, 0, 0);
    run_period(-1, 1'b0, '0, '0);
    check_period("cd_rev", 0, 128, 0, 0);

    // Asynchronous reset in the middle of a forward pulse
    lft_spd = 12'sd1024;
    run_period(-1, 1'b0, '0, '0);
    check_period("pre_rst", 0, 0, 0, 0);
    run_period(-1, 1'b0, '0, '0);
    check_period("pre_rst_fwd", 1024, 0, 0, 0);
    for (int k = 0; k < 200 && cnt_m != 11'h050; k++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("pre_rst_lf", int'(lft_fwd_pwm), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", int'(outs), 0);
    chk("async_rst_cnt", int'(dut.cnt_q), 0);
    chk("async_rst_synch", int'(PWM_synch), 0);
    @(negedge clk);
    rst_n = 1'b1;
    align_to_wrap("align_post_rst");
    run_period(-1, 1'b0, '0, '0);
    check_period("post_rst", 1024, 0, 0, 0);

    chk("synch_decode_errors", sync_err, 0);
    chk("exclusivity_errors", excl_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
